seq_alu: RTL

Parametrised multi-cycle successor to the datapath ALU. Keeps the same 5-bit opcode map, but the operand width is a parameter and every result is registered. MUL uses an iterative radix-2 Booth multiplier and DIV uses an iterative signed restoring divider, replacing the combinational units. A start/busy/done handshake lets the control unit stall the Z register load until done.

---
 rtl/seq_alu.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle parametrised ALU with Booth multiplier and restoring divider
// Purpose: every result is registered; single-cycle ops finish one cycle after start,
//          MUL after WIDTH cycles (radix-2 Booth), DIV after WIDTH+1 cycles (signed restoring).
// Ports:   clock (rising edge), clear (async active-low reset),
//          start/Op/Branch/RA/RB (captured only in IDLE), busy, done (1-cycle pulse),
//          ResultHi/ResultLo (held between done pulses), flags {N,Z,C,V}.
// Optional: define SEQ_ALU_FLAGS_EN to build the flags logic; otherwise flags is tied to 0.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       Op,
    input  logic             Branch,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultHi,
    output logic [WIDTH-1:0] ResultLo,
    output logic [3:0]       flags
);

    localparam logic [2:0] S_IDLE = 3'd0, S_SINGLE = 3'd1, S_MUL = 3'd2, S_DIV = 3'd3, S_FIX = 3'd4;

    localparam logic [4:0] OP_LOAD = 5'b00000, OP_ADD  = 5'b00011, OP_SUB  = 5'b00100,
                           OP_AND  = 5'b00101, OP_OR   = 5'b00110, OP_ROR  = 5'b00111,
                           OP_ROL  = 5'b01000, OP_SHR  = 5'b01001, OP_SHRA = 5'b01010,
                           OP_SHL  = 5'b01011, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101,
                           OP_ORI  = 5'b01110, OP_DIV  = 5'b01111, OP_MUL  = 5'b10000,
                           OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_BR   = 5'b10011,
                           OP_SHLA = 5'b11111;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH-1);

    logic [2:0]       state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             br_q, br_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    // acc: Booth partial product (one guard bit) or divider remainder.
    // mq:  Booth multiplier shift register or divider dividend/quotient register.
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic             q1_q, q1_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [SHW-1:0]   sh, nsh;
    logic [WIDTH-1:0] add_r, sub_r, s_hi, s_lo;
    logic [WIDTH:0]   m_ext, bo_sum, bo_acc, rem_sh, trial;
    logic [WIDTH-1:0] bo_mq, dmag;
    logic             fin;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    // Single-cycle datapath on captured operands
    always_comb begin
        sh    = b_q[SHW-1:0];
        nsh   = -sh;              // (WIDTH - sh) mod WIDTH, rotate complement
        add_r = a_q + b_q;
        sub_r = a_q - b_q;
        s_hi  = '0;
        s_lo  = '0;
        case (op_q)
            OP_ADD, OP_ADDI, OP_LOAD: s_lo = add_r;
            OP_SUB:                   s_lo = sub_r;
            OP_AND, OP_ANDI:          s_lo = a_q & b_q;
            OP_OR, OP_ORI:            s_lo = a_q | b_q;
            OP_NEG:                   s_lo = -b_q;
            OP_NOT:                   s_lo = ~b_q;
            OP_SHR:                   s_lo = a_q >> sh;
            OP_SHRA:                  s_lo = $signed(a_q) >>> sh;
            OP_SHL, OP_SHLA:          s_lo = a_q << sh;
            // amount 0 gives a_q | a_q, so no special case is needed
            OP_ROR:                   s_lo = (a_q >> sh) | (a_q << nsh);
            OP_ROL:                   s_lo = (a_q << sh) | (a_q >> nsh);
            OP_BR:                    s_lo = br_q ? add_r : a_q;
            // DIV only reaches the single-cycle path when the divisor is zero
            OP_DIV: begin
                s_lo = '1;
                s_hi = a_q;
            end
            default: ;
        endcase
    end

    // One Booth step and one restoring-division step
    always_comb begin
        m_ext = {a_q[WIDTH-1], a_q};
        case ({mq_q[0], q1_q})
            2'b01:   bo_sum = acc_q + m_ext;
            2'b10:   bo_sum = acc_q - m_ext;
            default: bo_sum = acc_q;
        endcase
        bo_acc = {bo_sum[WIDTH], bo_sum[WIDTH:1]};
        bo_mq  = {bo_sum[0], mq_q[WIDTH-1:1]};

        dmag   = b_q[WIDTH-1] ? -b_q : b_q;
        rem_sh = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dmag};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        q1_d    = q1_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        fin     = 1'b0;
        fin_hi  = '0;
        fin_lo  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = Op;
                    a_d   = RA;
                    b_d   = RB;
                    br_d  = Branch;
                    cnt_d = '0;
                    acc_d = '0;
                    q1_d  = 1'b0;
                    if (Op == OP_MUL) begin
                        mq_d    = RB;
                        state_d = S_MUL;
                    end else if (Op == OP_DIV && RB != '0) begin
                        mq_d    = RA[WIDTH-1] ? -RA : RA;
                        state_d = S_DIV;
                    end else begin
                        state_d = S_SINGLE;
                    end
                end
            end
            S_SINGLE: begin
                fin     = 1'b1;
                fin_hi  = s_hi;
                fin_lo  = s_lo;
                state_d = S_IDLE;
            end
            S_MUL: begin
                acc_d = bo_acc;
                mq_d  = bo_mq;
                q1_d  = mq_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    fin     = 1'b1;
                    fin_hi  = bo_acc[WIDTH-1:0];
                    fin_lo  = bo_mq;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = trial[WIDTH] ? rem_sh : trial;
                mq_d  = {mq_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                // quotient negative when signs differ; remainder follows the dividend
                fin     = 1'b1;
                fin_lo  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -mq_q : mq_q;
                fin_hi  = a_q[WIDTH-1] ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) begin
            done_d = 1'b1;
            hi_d   = fin_hi;
            lo_d   = fin_lo;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            q1_q    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            q1_q    <= q1_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign ResultHi = hi_q;
    assign ResultLo = lo_q;

`ifdef SEQ_ALU_FLAGS_EN
    logic [3:0]     flg_q, flg_d;
    logic [WIDTH:0] add_x;
    logic           s_c, s_v, f_n, f_z, f_c, f_v;

    always_comb begin
        add_x = {1'b0, a_q} + {1'b0, b_q};
        s_c   = 1'b0;
        s_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                s_c = add_x[WIDTH];
                s_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_ADDI, OP_LOAD: s_c = add_x[WIDTH];
            OP_BR:            s_c = br_q & add_x[WIDTH];
            OP_SUB: begin
                s_c = (a_q >= b_q);
                s_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_NEG:           s_v = (b_q == MIN_VAL);
            OP_DIV:           s_v = 1'b1;   // single-cycle DIV means divide by zero
            default: ;
        endcase
        f_n   = (state_q == S_MUL) ? fin_hi[WIDTH-1] : fin_lo[WIDTH-1];
        f_z   = (fin_lo == '0) && ((state_q != S_MUL) || (fin_hi == '0));
        f_c   = (state_q == S_SINGLE) && s_c;
        f_v   = (state_q == S_SINGLE) ? s_v
              : ((state_q == S_FIX) && (a_q == MIN_VAL) && (b_q == '1));
        flg_d = fin ? {f_n, f_z, f_c, f_v} : flg_q;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) flg_q <= 4'b0000;
        else        flg_q <= flg_d;
    end

    assign flags = flg_q;
`else
    assign flags = 4'b0000;
`endif

endmodule
